// File: rtl/seg_pipelined_adder.sv
// Segmented, skewed-pipeline adder/subtractor with valid/ready flow control.
// Stage 0 registers the operands; stages 1..SEGMENTS each ripple one SEG_W-bit slice.
module seg_pipelined_adder #(
    parameter int unsigned WIDTH    = 95,
    parameter int unsigned SEGMENTS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic             ovf
);
    localparam int unsigned SEG_W = (WIDTH + SEGMENTS - 1) / SEGMENTS;

    logic [WIDTH-1:0] a_q [0:SEGMENTS-1];
    logic [WIDTH-1:0] a_d [0:SEGMENTS-1];
    logic [WIDTH-1:0] b_q [0:SEGMENTS-1];
    logic [WIDTH-1:0] b_d [0:SEGMENTS-1];
    logic [WIDTH-1:0] r_q [0:SEGMENTS];
    logic [WIDTH-1:0] r_d [0:SEGMENTS];
    logic             c_q [0:SEGMENTS];
    logic             c_d [0:SEGMENTS];
    logic             v_q [0:SEGMENTS];
    logic             v_d [0:SEGMENTS];
    logic             ovf_q;
    logic             ovf_d;
    logic             adv;
    logic             cy;

    assign adv       = !v_q[SEGMENTS] || out_ready;
    assign in_ready  = adv;
    assign out_valid = v_q[SEGMENTS];
    assign sum       = {c_q[SEGMENTS], r_q[SEGMENTS]};
    assign ovf       = ovf_q;

    always_comb begin
        cy     = 1'b0;
        a_d[0] = a;
        b_d[0] = b ^ {WIDTH{sub}};
        r_d[0] = '0;
        c_d[0] = sub;
        v_d[0] = in_valid;
        for (int unsigned k = 1; k < SEGMENTS; k++) begin
            a_d[k] = a_q[k-1];
            b_d[k] = b_q[k-1];
        end
        // Stage k only touches bits inside its slice; slices past WIDTH are empty and just forward the carry.
        for (int unsigned k = 1; k <= SEGMENTS; k++) begin
            r_d[k] = r_q[k-1];
            v_d[k] = v_q[k-1];
            cy     = c_q[k-1];
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (i >= (k - 1) * SEG_W && i < k * SEG_W) begin
                    r_d[k][i] = a_q[k-1][i] ^ b_q[k-1][i] ^ cy;
                    cy        = (a_q[k-1][i] & b_q[k-1][i]) | (cy & (a_q[k-1][i] ^ b_q[k-1][i]));
                end
            end
            c_d[k] = cy;
        end
        ovf_d = (a_q[SEGMENTS-1][WIDTH-1] == b_q[SEGMENTS-1][WIDTH-1])
             && (r_d[SEGMENTS][WIDTH-1] != a_q[SEGMENTS-1][WIDTH-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < SEGMENTS; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
            for (int unsigned k = 0; k <= SEGMENTS; k++) begin
                r_q[k] <= '0;
                c_q[k] <= 1'b0;
                v_q[k] <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else if (adv) begin
            a_q   <= a_d;
            b_q   <= b_d;
            r_q   <= r_d;
            c_q   <= c_d;
            v_q   <= v_d;
            ovf_q <= ovf_d;
        end
    end
endmodule

// File: tb/tb_seg_pipelined_adder.sv
// Scoreboard bench: directed vectors on an 8-bit/2-segment instance plus
// randomised-handshake sweeps of three other width/segment configurations.
module tb_seg_pipelined_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- directed instance: WIDTH=8, SEGMENTS=2 ----------------
    logic       rst_n;
    logic       srst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] sum;
    logic       ovf;
    logic [9:0] exp_q [$];

    seg_pipelined_adder #(.WIDTH(8), .SEGMENTS(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .ovf      (ovf)
    );

    initial begin : monitor
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got {ovf,sum}=0x%0h with no result outstanding", {ovf, sum});
                end else begin
                    e = exp_q.pop_front();
                    check("result", {ovf, sum}, e);
                end
            end
        end
    end

    // Call at posedge+#1; returns at posedge+#1 just after the accepting edge.
    task automatic send(input logic [7:0] xa, input logic [7:0] xb, input logic xs, input logic [9:0] e);
        int unsigned n = 0;
        a = xa;
        b = xb;
        sub = xs;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                break;
            end
            n++;
            if (n > 50) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic check_latency(input string name, input int unsigned n);
        for (int unsigned i = 1; i <= n; i++) begin
            @(posedge clk);
            #1;
            check(name, out_valid, (i == n));
        end
    endtask

    task automatic drain(input string name);
        int unsigned n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d results outstanding, required 0", name, exp_q.size());
        end
    endtask

    // ---------------- parameter sweep instances ----------------
    for (genvar g = 0; g < 3; g++) begin : sweep
        localparam int unsigned W = (g == 0) ? 95 : ((g == 1) ? 5 : 1);
        localparam int unsigned S = (g == 0) ? 4 : ((g == 1) ? 4 : 1);
        logic         iv;
        logic         ir;
        logic         s;
        logic         ov;
        logic         orr;
        logic         of;
        logic         done;
        logic [W-1:0] sa;
        logic [W-1:0] sb;
        logic [W:0]   ssum;
        logic [W+1:0] q [$];

        seg_pipelined_adder #(.WIDTH(W), .SEGMENTS(S)) dut (
            .clk      (clk),
            .rst_n    (srst_n),
            .in_valid (iv),
            .in_ready (ir),
            .a        (sa),
            .b        (sb),
            .sub      (s),
            .out_valid(ov),
            .out_ready(orr),
            .sum      (ssum),
            .ovf      (of)
        );

        initial begin : ready_gen
            orr = 1'b1;
            forever begin
                @(posedge clk);
                #1;
                orr = ($urandom_range(3) != 0);
            end
        end

        initial begin : drive
            int unsigned  sent = 0;
            int unsigned  n = 0;
            logic         acc = 1'b0;
            logic [W-1:0] bx;
            logic [W:0]   e;
            logic         eo;
            iv = 1'b0;
            sa = '0;
            sb = '0;
            s = 1'b0;
            done = 1'b0;
            @(posedge srst_n);
            while (sent < 60 && n < 2000) begin
                @(posedge clk);
                #1;
                n++;
                if (acc) begin
                    iv = 1'b0;
                    acc = 1'b0;
                end
                if (!iv && $urandom_range(3) != 0) begin
                    sa = W'({$urandom(), $urandom(), $urandom()});
                    sb = W'({$urandom(), $urandom(), $urandom()});
                    s = 1'($urandom_range(1));
                    iv = 1'b1;
                end
                @(negedge clk);
                if (iv && ir) begin
                    bx = sb ^ {W{s}};
                    e = {1'b0, sa} + {1'b0, bx} + (W+1)'(s);
                    eo = (sa[W-1] == bx[W-1]) && (e[W-1] != sa[W-1]);
                    q.push_back({eo, e});
                    sent++;
                    acc = 1'b1;
                end
            end
            @(posedge clk);
            #1;
            iv = 1'b0;
            n = 0;
            while (q.size() != 0 && n < 500) begin
                @(posedge clk);
                #1;
                n++;
            end
            checks++;
            if (sent != 60 || q.size() != 0) begin
                errors++;
                $display("FAIL sweep%0d_complete: sent %0d outstanding %0d, required 60 and 0", g, sent, q.size());
            end
            done = 1'b1;
        end

        initial begin : mon
            logic [W+1:0] e;
            forever begin
                @(negedge clk);
                if (srst_n && ov && orr) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sweep%0d_unexpected: got 0x%0h with no result outstanding", g, {of, ssum});
                    end else begin
                        e = q.pop_front();
                        check($sformatf("sweep%0d_result", g), {of, ssum}, e);
                    end
                end
            end
        end
    end

    // ---------------- main directed sequence ----------------
    initial begin : main
        int unsigned n;
        rst_n = 1'b0;
        srst_n = 1'b0;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        sub = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_sum", sum, 9'h000);
        check("reset_ovf", ovf, 1'b0);
        check("reset_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        srst_n = 1'b1;
        check("post_reset_in_ready", in_ready, 1'b1);

        send(8'hFF, 8'h01, 1'b0, {1'b0, 9'h100});
        check_latency("latency_add_carry", 2);
        send(8'h7F, 8'h01, 1'b0, {1'b1, 9'h080});
        check_latency("latency_ovf", 2);
        send(8'h05, 8'h07, 1'b1, {1'b0, 9'h0FE});
        send(8'h80, 8'h01, 1'b1, {1'b1, 9'h17F});
        send(8'h00, 8'h00, 1'b1, {1'b0, 9'h100});
        send(8'hFF, 8'hFF, 1'b1, {1'b0, 9'h100});
        send(8'h80, 8'h80, 1'b0, {1'b1, 9'h100});
        send(8'h00, 8'h00, 1'b0, {1'b0, 9'h000});
        send(8'h3C, 8'h5A, 1'b0, {1'b1, 9'h096});
        send(8'h12, 8'h34, 1'b1, {1'b0, 9'h0DE});
        drain("drain_directed");

        fork
            begin
                send(8'h10, 8'h01, 1'b0, {1'b0, 9'h011});
                send(8'h11, 8'h01, 1'b0, {1'b0, 9'h012});
                send(8'h12, 8'h01, 1'b0, {1'b0, 9'h013});
                send(8'h13, 8'h01, 1'b0, {1'b0, 9'h014});
            end
            begin
                n = 0;
                while (!out_valid && n < 50) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_in_ready", in_ready, 1'b0);
                    check("stall_out_valid", out_valid, 1'b1);
                    check("stall_sum", sum, 9'h011);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain("drain_backpressure");

        // Two transactions in flight, the older one parked at the output.
        out_ready = 1'b0;
        send(8'h7F, 8'h7F, 1'b0, {1'b1, 9'h0FE});
        send(8'h40, 8'h40, 1'b0, {1'b1, 9'h080});
        @(posedge clk);
        #1;
        check("pre_reset_out_valid", out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_out_valid", out_valid, 1'b0);
        check("async_reset_sum", sum, 9'h000);
        check("async_reset_ovf", ovf, 1'b0);
        check("async_reset_in_ready", in_ready, 1'b1);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("no_stale_out_valid", out_valid, 1'b0);
        end
        @(posedge clk);
        #1;
        send(8'h01, 8'h01, 1'b0, {1'b0, 9'h002});
        check_latency("latency_after_reset", 2);
        drain("drain_after_reset");

        n = 0;
        while (!(sweep[0].done && sweep[1].done && sweep[2].done) && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (!(sweep[0].done && sweep[1].done && sweep[2].done)) begin
            errors++;
            $display("FAIL sweep_timeout: sweeps not complete after %0d cycles, required complete", n);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/seg_pipelined_adder.md
# seg_pipelined_adder

Parametrised, segmented, pipelined adder/subtractor with a valid/ready handshake. It is the next generation of the registered two-operand adder used in the arithmetic benchmark circuits. The carry chain is split into `SEGMENTS` registered slices so that width and pipeline depth can be swept independently. It sits between operand producers and a result consumer that may apply backpressure.

## Interface
Parameters:
- `WIDTH`, 95: operand width in bits. Legal range is 1 or more.
- `SEGMENTS`, 4: number of carry-chain slices, which also sets the pipeline depth. Legal range is 1 to `WIDTH`.
- Derived `SEG_W` = ceil(`WIDTH`/`SEGMENTS`). The last slice takes the remainder bits.

Ports:
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: operands and `sub` are valid.
- `in_ready`, output, 1: block accepts operands this cycle.
- `a`, input, `WIDTH`: operand A, unsigned or two's complement.
- `b`, input, `WIDTH`: operand B.
- `sub`, input, 1: 0 computes a+b, 1 computes a−b.
- `out_valid`, output, 1: `sum` and `ovf` hold a result.
- `out_ready`, input, 1: consumer takes the result.
- `sum`, output, `WIDTH`+1: {carry, result}.
- `ovf`, output, 1: signed two's-complement overflow.

One clock; reset is asynchronous and active-low. All state is cleared the moment `rst_n` falls, independent of `clk`.

## Operation
- **Global advance:** `adv` = !`out_valid` || `out_ready`. `in_ready` = `adv` (combinational). When `adv` is 0 every pipeline register, including the valid bits, holds its value.
- **Accept:** an accept occurs on a rising edge with `in_valid` && `in_ready`.
- **Stage 0 capture:** `a`, `b` XOR {`WIDTH`{`sub`}}, carry-in = `sub`, and valid = `in_valid`.
  - When `adv`=1 and `in_valid`=0, a bubble (valid=0) enters.
- **Stage k (k = 1..`SEGMENTS`):**
  - Adds slice k−1, bits [(k−1)·`SEG_W` +: width_k], using the carry registered by stage k−1.
  - Registers the slice sum and carry-out.
  - Forwards the already-computed lower result bits and the still-unused upper operand bits unchanged (skewed pipeline).
- **Final stage outputs:**
  - `sum`[`WIDTH`-1:0] is the concatenated slice sums.
  - `sum`[`WIDTH`] is the final carry-out. In subtract mode it is 1 when a ≥ b unsigned (no borrow).
  - `ovf` = (a_msb == b'_msb) && (result_msb != a_msb), where b' is the possibly inverted b.
- **Arithmetic:** modulo 2^(`WIDTH`+1) on the {carry, result} form. There is no saturation.
- **Bubbles:** bubbles travel through the pipeline in place. There is no compaction, so throughput is one result per cycle when `out_ready` stays 1.
- **Mixed operations:** `sub` is captured per transaction, so add and subtract may interleave freely.
- **Reset values:** `out_valid`=0, `sum`=0, `ovf`=0, all internal valid bits 0, all data registers 0.
  - `in_ready` = 1 during and after reset, because `out_valid`=0.
  - Reset mid-stream discards every in-flight transaction. No output is produced for them.

## Timing
- **Latency:** operands accepted at edge E0 appear with `out_valid`=1 after edge E0+`SEGMENTS`, as long as there are no stalls.
  - `SEGMENTS`=1 gives 1 cycle (input register plus one registered add).
- Each cycle with `adv`=0 adds exactly one cycle to the latency of every in-flight transaction.
- `out_valid` && !`out_ready`: `sum`, `ovf` and `out_valid` stay stable until the cycle `out_ready`=1.
- **Simultaneous events:** in one cycle with `out_valid`=1, `out_ready`=1 and `in_valid`=1:
  - the output is consumed,
  - a new operand is accepted,
  - the pipeline shifts by one.
- Worst combinational path is one `SEG_W`-bit ripple, plus the `adv` fan-out to all enables.
- Width rule: when `WIDTH` mod `SEGMENTS` ≠ 0, the last slice is narrower. When ceil-division makes trailing slices empty (for example `WIDTH`=5, `SEGMENTS`=4), those slices are zero-width pass-through stages that add latency only.

## Test plan
All scenarios use `WIDTH`=8 and `SEGMENTS`=2 unless noted.
- **Add with carry:** a=0xFF, b=0x01, sub=0 → after 2 cycles `sum`=0x100, `ovf`=0.
- **Signed overflow:** a=0x7F, b=0x01, sub=0 → `sum`=0x080, `ovf`=1.
- **Subtract with borrow:** a=0x05, b=0x07, sub=1 → `sum`=0x0FE (bit8=0, borrow), `ovf`=0. Then a=0x80, b=0x01, sub=1 → `sum`=0x17F, `ovf`=1.
- **Backpressure:** stream 4 back-to-back adds (0x10+0x01 … 0x13+0x01) with `out_ready`=0 for 3 cycles after the first `out_valid`.
  - `in_ready`=0 while stalled.
  - Results 0x011, 0x012, 0x013, 0x014 are delivered in order, none lost or duplicated.
  - `sum` stays stable while stalled.
- **Reset mid-stream:** drop `rst_n` asynchronously with 2 transactions in flight.
  - `out_valid`, `sum` and `ovf` go to 0 immediately.
  - After release, no stale result ever appears.
  - The first new transaction, 0x01+0x01, yields 0x002 after 2 cycles.
- **Parameter sweep:** random checks against a reference model for `WIDTH`=95/`SEGMENTS`=4 (latency 4), `WIDTH`=5/`SEGMENTS`=4 (latency 4), and `WIDTH`=1/`SEGMENTS`=1 (latency 1).
  - Use random `in_valid`/`out_ready` patterns.
  - Require exact match and in-order delivery.
